// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous sprite ROM between NREQ requesters.
// A ROM_LAT-deep tag pipeline sends each returned palette index back to the requester that issued it.
module sprite_rom_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 13,
   parameter int DW      = 4,
   parameter int ROM_LAT = 1
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] addr,
   output logic [NREQ-1:0]    gnt,
   output logic [AW-1:0]      rom_address,
   input  logic [DW-1:0]      rom_q,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [NREQ-1:0]    tag_oh_q [ROM_LAT];
   logic [NREQ-1:0]    tag_oh_d [ROM_LAT];

   logic               grant_s;
   logic [PW-1:0]      gidx_s;
   logic [PW:0]        cand_s;
   logic               hit_s;

   // Scan from rr_ptr downwards in priority so the nearest requester at or after rr_ptr wins.
   always_comb begin
      grant_s = 1'b0;
      gidx_s  = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand_s  = {1'b0, rr_ptr_q} + (PW+1)'(k);
         cand_s  = (cand_s >= (PW+1)'(NREQ)) ? (cand_s - (PW+1)'(NREQ)) : cand_s;
         hit_s   = reset_n & en & req[cand_s[PW-1:0]];
         grant_s = grant_s | hit_s;
         gidx_s  = hit_s ? cand_s[PW-1:0] : gidx_s;
      end
   end

   // Grant, ROM address mux and next pointer; the address register holds the last grant to keep the ROM bus quiet.
   always_comb begin
      gnt         = grant_s ? (NREQ'(1'b1) << gidx_s) : '0;
      rom_address = grant_s ? addr[gidx_s*AW +: AW] : addr_q;
      addr_d      = rom_address;
      if (grant_s) begin
         rr_ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : (gidx_s + PW'(1));
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Tag pipeline next state: stage 0 records who was granted, later stages shift.
   always_comb begin
      tag_vld_d[0] = grant_s;
      tag_oh_d[0]  = gnt;
      for (int s = 1; s < ROM_LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_oh_d[s]  = tag_oh_q[s-1];
      end
   end

   // State registers; an asynchronous reset drops every read still in flight.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q  <= '0;
         addr_q    <= '0;
         tag_vld_q <= '0;
         for (int s = 0; s < ROM_LAT; s++) begin
            tag_oh_q[s] <= '0;
         end
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         addr_q    <= addr_d;
         tag_vld_q <= tag_vld_d;
         for (int s = 0; s < ROM_LAT; s++) begin
            tag_oh_q[s] <= tag_oh_d[s];
         end
      end
   end

   assign rvalid = tag_vld_q[ROM_LAT-1] ? tag_oh_q[ROM_LAT-1] : '0;
   assign rdata  = rom_q;
   assign busy   = |tag_vld_q;

endmodule
